// File: rtl/led_pattern_sequencer.sv
// Mode-driven LED pattern sequencer: valid/ready mode commands, tick-stepped patterns.
// Optional macro LED_SEQ_CHASE_BOUNCE_EN makes CHASE ping-pong instead of wrapping.
module led_pattern_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int BURST_LEN   = 3,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd_mode,
    output logic                cmd_ready,
    output logic [NUM_LEDS-1:0] leds,
    output logic [2:0]          mode
);

    localparam logic [2:0] M_OFF   = 3'd0;
    localparam logic [2:0] M_ON    = 3'd1;
    localparam logic [2:0] M_BLINK = 3'd2;
    localparam logic [2:0] M_CHASE = 3'd3;
    localparam logic [2:0] M_BURST = 3'd4;

    localparam int STEP_MAX = 2 * BURST_LEN + PAUSE_TICKS - 1;
    localparam int SW       = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_MAX);
    localparam logic [SW-1:0] BLINK_END = SW'(2 * BURST_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    logic [2:0]    pend;
    logic [SW-1:0] step;
    logic [SW-1:0] step_nxt;
    logic          burst_lit;
`ifdef LED_SEQ_CHASE_BOUNCE_EN
    logic          dir_up;
`endif

    always_comb begin
        step_nxt  = (step == STEP_LAST) ? '0 : step + 1'b1;
        burst_lit = (step_nxt < BLINK_END) && !step_nxt[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            leds      <= '0;
            mode      <= M_OFF;
            pend      <= M_OFF;
            step      <= '0;
`ifdef LED_SEQ_CHASE_BOUNCE_EN
            dir_up    <= 1'b1;
`endif
        end else begin
            case (state)
                LOAD: begin
                    state     <= RUN;
                    cmd_ready <= 1'b1;
                    mode      <= pend;
                    step      <= '0;
`ifdef LED_SEQ_CHASE_BOUNCE_EN
                    dir_up    <= 1'b1;
`endif
                    case (pend)
                        M_ON, M_BLINK, M_BURST: leds <= '1;
                        M_CHASE:                leds <= NUM_LEDS'(1);
                        default:                leds <= '0;
                    endcase
                end
                default: begin
                    // cmd_ready is high in IDLE and RUN, so cmd_valid alone is an accept;
                    // an accept takes priority and the coinciding tick is dropped.
                    if (cmd_valid) begin
                        state     <= LOAD;
                        cmd_ready <= 1'b0;
                        pend      <= (cmd_mode <= M_BURST) ? cmd_mode : M_OFF;
                    end else if (tick && state == RUN) begin
                        case (mode)
                            M_BLINK: leds <= ~leds;
                            M_CHASE: begin
`ifdef LED_SEQ_CHASE_BOUNCE_EN
                                if (dir_up) begin
                                    if (leds[NUM_LEDS-1]) begin
                                        leds   <= leds >> 1;
                                        dir_up <= 1'b0;
                                    end else begin
                                        leds   <= leds << 1;
                                    end
                                end else begin
                                    if (leds[0]) begin
                                        leds   <= leds << 1;
                                        dir_up <= 1'b1;
                                    end else begin
                                        leds   <= leds >> 1;
                                    end
                                end
`else
                                leds <= {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
`endif
                            end
                            M_BURST: begin
                                step <= step_nxt;
                                leds <= {NUM_LEDS{burst_lit}};
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
